// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and types for the FIFO subsystem.
//   DEPTH        number of storage entries
//   ADDR_W       storage index width (low pointer bits)
//   PTR_W        pointer width (index plus one wrap bit)
//   AF_LEVEL_DEF default almost_full threshold  (count >= level)
//   AE_LEVEL_DEF default almost_empty threshold (count <= level)
//   count_t      occupancy type, able to hold 0..DEPTH
package fifo_pkg;

    localparam int DEPTH        = 16;
    localparam int ADDR_W       = 4;
    localparam int PTR_W        = ADDR_W + 1;
    localparam int AF_LEVEL_DEF = 14;
    localparam int AE_LEVEL_DEF = 2;

    typedef logic [PTR_W-1:0] count_t;

endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: one wrapping FIFO pointer. The low ADDR_W bits index the storage,
// the MSB is the wrap bit that tells full from empty. It increments modulo
// 2**PTR_W whenever en is high.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; returns the pointer to 0
//   en     advance the pointer by one at this edge
//   ptr    current pointer value
module fifo_ptr
    import fifo_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [PTR_W-1:0] ptr
);

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every reader at the same edge sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= ptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer and flag controller for the 16-entry byte FIFO storage.
// Accepts push/pop against the registered full/empty flags, drives the storage
// write/read enables and addresses, and reports occupancy, thresholds and a
// read-data-valid strobe aligned to the storage's registered data_out.
//
// Optional feature: define FIFO_CTRL_ERR_EN to build sticky overflow/underflow
// error registers. Without it both outputs are constant 0.
//
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   push, pop        producer / consumer requests
//   mem_wr_en        storage write enable (accepted push)
//   mem_wr_addr      storage write index {1'b0, wr_ptr[3:0]}
//   mem_rd_en        storage read enable (accepted pop)
//   mem_rd_addr      storage read index  {1'b0, rd_ptr[3:0]}
//   rd_valid         storage data_out holds the popped byte this cycle
//   full, empty      count == DEPTH, count == 0
//   almost_full      count >= AF_LEVEL
//   almost_empty     count <= AE_LEVEL
//   count            occupancy 0..DEPTH
//   overflow         sticky: push attempted while full
//   underflow        sticky: pop attempted while empty
module fifo_ctrl #(
    parameter int DEPTH    = fifo_pkg::DEPTH,
    parameter int AF_LEVEL = fifo_pkg::AF_LEVEL_DEF,
    parameter int AE_LEVEL = fifo_pkg::AE_LEVEL_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    output logic       mem_wr_en,
    output logic [4:0] mem_wr_addr,
    output logic       mem_rd_en,
    output logic [4:0] mem_rd_addr,
    output logic       rd_valid,
    output logic       full,
    output logic       empty,
    output logic       almost_full,
    output logic       almost_empty,
    output logic [4:0] count,
    output logic       overflow,
    output logic       underflow
);

    import fifo_pkg::*;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    count_t           occ;
    logic             push_acc;
    logic             pop_acc;

    // Flags and count are pure functions of the registered pointers, so they
    // only change just after a clock edge and never follow push/pop directly.
    assign occ          = wr_ptr - rd_ptr;
    assign count        = occ;
    assign full         = (occ == count_t'(DEPTH));
    assign empty        = (wr_ptr == rd_ptr);
    assign almost_full  = (occ >= count_t'(AF_LEVEL));
    assign almost_empty = (occ <= count_t'(AE_LEVEL));

    // Requests are judged against the current flags; a rejected one is simply
    // dropped. Simultaneous push/pop on an empty FIFO accepts only the push
    // (no write-through), on a full FIFO only the pop.
    assign push_acc = push & ~full;
    assign pop_acc  = pop & ~empty;

    assign mem_wr_en   = push_acc;
    assign mem_rd_en   = pop_acc;
    assign mem_wr_addr = {1'b0, wr_ptr[ADDR_W-1:0]};
    assign mem_rd_addr = {1'b0, rd_ptr[ADDR_W-1:0]};

    fifo_ptr u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .en    (push_acc),
        .ptr   (wr_ptr)
    );

    fifo_ptr u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .en    (pop_acc),
        .ptr   (rd_ptr)
    );

    // The storage registers the addressed byte on the pop edge, so the data
    // is on its output one cycle later; rd_valid marks exactly that cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= pop_acc;
        end
    end

`ifdef FIFO_CTRL_ERR_EN
    logic overflow_q;
    logic underflow_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push && full) begin
                overflow_q <= 1'b1;
            end
            if (pop && empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed bench for fifo_ctrl with a byte storage stub and a
// queue-based reference model compared against the DUT every cycle.
module tb_fifo_ctrl;

    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic       clk;
    logic       reset;
    logic       push;
    logic       pop;
    logic [7:0] wr_data;
    logic       mem_wr_en;
    logic [4:0] mem_wr_addr;
    logic       mem_rd_en;
    logic [4:0] mem_rd_addr;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int n_vec = 0;
    int n_err = 0;

    fifo_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .pop          (pop),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_addr  (mem_wr_addr),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_addr  (mem_rd_addr),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Storage stub: write on mem_wr_en, registered read on mem_rd_en.
    logic [7:0] mem [0:31];
    logic [7:0] data_out;
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_wr_addr] <= wr_data;
        if (mem_rd_en) data_out <= mem[mem_rd_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a queue of stored bytes plus running push/pop totals.
    logic [7:0] m_q[$];
    int         m_wr_tot;
    int         m_rd_tot;
    bit         m_rd_valid;
    logic [7:0] m_exp_data;
    bit         m_ovf;
    bit         m_unf;
    bit         started = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_q.delete();
            m_wr_tot   = 0;
            m_rd_tot   = 0;
            m_rd_valid = 0;
            m_ovf      = 0;
            m_unf      = 0;
            started    = 1;
        end else if (started) begin
            bit pa;
            bit qa;
            pa = push && (m_q.size() < DEPTH);
            qa = pop && (m_q.size() > 0);
            if (push && m_q.size() == DEPTH) m_ovf = 1;
            if (pop && m_q.size() == 0) m_unf = 1;
            m_rd_valid = qa;
            if (qa) begin
                m_exp_data = m_q.pop_front();
                m_rd_tot++;
            end
            if (pa) begin
                m_q.push_back(wr_data);
                m_wr_tot++;
            end
        end
    end

    // Compare process: mid-cycle, against the model's current state.
    always @(negedge clk) begin
        if (started) begin
            int c;
            c = m_q.size();
            check("mem_wr_en",    mem_wr_en,    push && c < DEPTH);
            check("mem_rd_en",    mem_rd_en,    pop && c > 0);
            check("mem_wr_addr",  mem_wr_addr,  m_wr_tot % 16);
            check("mem_rd_addr",  mem_rd_addr,  m_rd_tot % 16);
            check("count",        count,        c);
            check("full",         full,         c == DEPTH);
            check("empty",        empty,        c == 0);
            check("almost_full",  almost_full,  c >= AF);
            check("almost_empty", almost_empty, c <= AE);
            check("rd_valid",     rd_valid,     m_rd_valid);
            if (m_rd_valid) check("rd_data", data_out, m_exp_data);
`ifdef FIFO_CTRL_ERR_EN
            check("overflow",     overflow,     m_ovf);
            check("underflow",    underflow,    m_unf);
`else
            check("overflow",     overflow,     0);
            check("underflow",    underflow,    0);
`endif
        end
    end

    // Apply one cycle of inputs; returns 1 time unit after the consuming edge.
    task automatic drive(input logic p, input logic q, input logic [7:0] d);
        push    = p;
        pop     = q;
        wr_data = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        push = 1'b0; pop = 1'b0; wr_data = 8'h00;
        drive(0, 0, 0);
        drive(0, 0, 0);
        reset = 1'b0;

        // Reset state, hand-computed
        check("rst_empty", empty, 1);
        check("rst_ae",    almost_empty, 1);
        check("rst_full",  full, 0);
        check("rst_count", count, 0);
        check("rst_rdv",   rd_valid, 0);
        drive(0, 0, 0);

        // Fill with 0x01..0x10
        for (int i = 1; i <= 16; i++) begin
            drive(1, 0, 8'(i));
            check("fill_count", count, i);
            check("fill_af", almost_full, i >= 14);
        end
        check("fill_full", full, 1);

        // Push while full is dropped
        push = 1'b1; wr_data = 8'hEE;
        #1;
        check("ovf_wr_en", mem_wr_en, 0);
        @(posedge clk); #1;
        push = 1'b0;
        check("ovf_count", count, 16);
`ifdef FIFO_CTRL_ERR_EN
        check("ovf_flag", overflow, 1);
`endif

        // Drain: data 0x01..0x10 one cycle after each pop
        for (int i = 1; i <= 16; i++) begin
            drive(0, 1, 0);
            check("drain_rdv", rd_valid, 1);
            check("drain_data", data_out, i);
        end
        check("drain_empty", empty, 1);

        // 17th pop rejected
        pop = 1'b1;
        #1;
        check("unf_rd_en", mem_rd_en, 0);
        @(posedge clk); #1;
        pop = 1'b0;
        check("unf_rdv", rd_valid, 0);
`ifdef FIFO_CTRL_ERR_EN
        check("unf_flag", underflow, 1);
        check("ovf_sticky", overflow, 1);
`endif

        // Fill 8 then stream push+pop across the pointer wrap
        for (int i = 0; i < 8; i++) drive(1, 0, 8'h20 + 8'(i));
        check("half_count", count, 8);
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, 8'h40 + 8'(i));
            check("stream_count", count, 8);
            if (i < 8) check("stream_data", data_out, 8'h20 + 8'(i));
            else       check("stream_data", data_out, 8'h40 + 8'(i - 8));
        end

        // Grow to 10, pop to 9 (rd_valid high), then reset mid-stream
        drive(1, 0, 8'h60);
        drive(1, 0, 8'h61);
        drive(0, 1, 0);
        check("pre_rst_count", count, 9);
        check("pre_rst_rdv", rd_valid, 1);
        reset = 1'b1;
        drive(0, 0, 0);
        reset = 1'b0;
        check("mid_rst_count", count, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_rdv",   rd_valid, 0);
        check("mid_rst_ovf",   overflow, 0);
        check("mid_rst_unf",   underflow, 0);
        drive(0, 0, 0);
        drive(0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
